// File: rtl/pls_pkg.sv
// Shared constants and helpers for the watch's modulo-60 counter chain
// (both the up-counter and the countdown/timer down-counter).
package pls_pkg;

    localparam int MOD60  = 60;
    localparam int CNT_W  = 6;
    localparam int HALF60 = 30;

    // Smallest count width that can hold 0..modulus-1.
    function automatic int cnt_width(input int modulus);
        return (modulus < 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, with registered rise/fall
// pulses and a synchronous flush that drops any edge still in flight.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s0_q, s1_q, rise_q, fall_q;
    logic s0_d, s1_d, rise_d, fall_d;

    always_comb begin
        s0_d   = din;
        s1_d   = s0_q;
        rise_d = s0_q & ~s1_q;
        fall_d = s1_q & ~s0_q;
        if (flush) begin
            s0_d   = 1'b0;
            s1_d   = 1'b0;
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pls_dncnt_60.sv
// Modulo-MODULUS down-counter for the countdown/timer path: decrements on each
// falling plsi edge, borrows to the next stage on wrap, supports clear and preset.
module pls_dncnt_60
    import pls_pkg::*;
#(
    parameter int MODULUS = MOD60,
    parameter int WIDTH   = cnt_width(MODULUS),
    parameter bit WRAP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             plsi,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] qout,
    output logic             plso,
    output logic             bout,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] HALF_VAL = WIDTH'(MODULUS / 2);

    logic tick_ev, clr_ev;
    logic tick_rise_unused, clr_fall_unused;

    logic [WIDTH-1:0] qout_q, qout_d;
    logic             plso_q, plso_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    // A clear also flushes the tick pipeline so a tick racing it is lost, not deferred.
    sync_edge_det u_tick_sync (
        .clk   (clk),
        .rst   (rst),
        .flush (clr_ev),
        .din   (plsi),
        .rise  (tick_rise_unused),
        .fall  (tick_ev)
    );

    sync_edge_det u_clr_sync (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .din   (clr),
        .rise  (clr_ev),
        .fall  (clr_fall_unused)
    );

    always_comb begin
        qout_d = qout_q;
        bout_d = 1'b0;
        if (clr_ev) begin
            qout_d = '0;
        end else if (ld) begin
            qout_d = (ld_val > MAX_VAL) ? MAX_VAL : ld_val;
        end else if (tick_ev) begin
            if (qout_q != '0) begin
                qout_d = qout_q - WIDTH'(1);
            end else if (WRAP) begin
                qout_d = MAX_VAL;
                bout_d = 1'b1;
            end
        end
        // Flags follow the next count so they never lag qout by a cycle.
        plso_d = (qout_d >= HALF_VAL);
        zero_d = (qout_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qout_q <= '0;
            plso_q <= 1'b0;
            bout_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            qout_q <= qout_d;
            plso_q <= plso_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
        end
    end

    assign qout = qout_q;
    assign plso = plso_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_pls_dncnt_60.sv
// Directed bench for pls_dncnt_60: a vector table of preset/tick/clear steps plus
// hand-written sequences for latency, wrap, priority collisions, reset and WRAP=0.
module tb_pls_dncnt_60;

    typedef enum logic [1:0] {OP_LD, OP_TICK, OP_CLR} op_t;

    typedef struct {
        op_t        op;
        logic [5:0] val;
        logic [5:0] exp_q;
        logic       exp_plso;
        logic       exp_zero;
        int         exp_bouts;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, clr, plsi, ld;
    logic [5:0] ld_val;
    logic [5:0] qout, nw_qout;
    logic       plso, bout, zero;
    logic       nw_plso, nw_bout, nw_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int bout_cnt = 0;
    int nw_bout_cnt = 0;

    vec_t vecs [14];

    pls_dncnt_60 #(.MODULUS(60), .WIDTH(6), .WRAP(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .plsi   (plsi),
        .ld     (ld),
        .ld_val (ld_val),
        .qout   (qout),
        .plso   (plso),
        .bout   (bout),
        .zero   (zero)
    );

    pls_dncnt_60 #(.MODULUS(60), .WIDTH(6), .WRAP(1'b0)) dut_nw (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .plsi   (plsi),
        .ld     (ld),
        .ld_val (ld_val),
        .qout   (nw_qout),
        .plso   (nw_plso),
        .bout   (nw_bout),
        .zero   (nw_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bout === 1'b1)
            bout_cnt++;
        if (nw_bout === 1'b1)
            nw_bout_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulse();
        plsi = 1'b1;
        step(4);
        plsi = 1'b0;
        step(4);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic applyStimulus(input op_t op, input logic [5:0] val);
        case (op)
            OP_LD: begin
                ld = 1'b1;
                ld_val = val;
                step(1);
                ld = 1'b0;
                step(1);
            end
            OP_TICK: pulse();
            OP_CLR: begin
                clr = 1'b1;
                step(4);
                clr = 1'b0;
                step(2);
            end
            default: step(1);
        endcase
    endtask

    initial begin
        int b0, nb0;

        vecs[0]  = '{OP_LD,   6'd5,  6'd5,  1'b0, 1'b0, 0};
        vecs[1]  = '{OP_TICK, 6'd0,  6'd4,  1'b0, 1'b0, 0};
        vecs[2]  = '{OP_TICK, 6'd0,  6'd3,  1'b0, 1'b0, 0};
        vecs[3]  = '{OP_TICK, 6'd0,  6'd2,  1'b0, 1'b0, 0};
        vecs[4]  = '{OP_TICK, 6'd0,  6'd1,  1'b0, 1'b0, 0};
        vecs[5]  = '{OP_TICK, 6'd0,  6'd0,  1'b0, 1'b1, 0};
        vecs[6]  = '{OP_TICK, 6'd0,  6'd59, 1'b1, 1'b0, 1};
        vecs[7]  = '{OP_LD,   6'd63, 6'd59, 1'b1, 1'b0, 0};
        vecs[8]  = '{OP_LD,   6'd30, 6'd30, 1'b1, 1'b0, 0};
        vecs[9]  = '{OP_TICK, 6'd0,  6'd29, 1'b0, 1'b0, 0};
        vecs[10] = '{OP_LD,   6'd10, 6'd10, 1'b0, 1'b0, 0};
        vecs[11] = '{OP_CLR,  6'd0,  6'd0,  1'b0, 1'b1, 0};
        vecs[12] = '{OP_TICK, 6'd0,  6'd59, 1'b1, 1'b0, 1};
        vecs[13] = '{OP_LD,   6'd0,  6'd0,  1'b0, 1'b1, 0};

        rst = 1'b0;
        clr = 1'b0;
        plsi = 1'b0;
        ld = 1'b0;
        ld_val = '0;
        step(1);
        doReset();

        checkOutput("reset qout", qout, 0);
        checkOutput("reset plso", plso, 0);
        checkOutput("reset bout", bout, 0);
        checkOutput("reset zero", zero, 1);
        checkOutput("reset nw qout", nw_qout, 0);
        checkOutput("reset nw zero", nw_zero, 1);

        for (int i = 0; i < 14; i++) begin
            b0 = bout_cnt;
            applyStimulus(vecs[i].op, vecs[i].val);
            checkOutput($sformatf("vec%0d qout", i), qout, vecs[i].exp_q);
            checkOutput($sformatf("vec%0d plso", i), plso, vecs[i].exp_plso);
            checkOutput($sformatf("vec%0d zero", i), zero, vecs[i].exp_zero);
            checkOutput($sformatf("vec%0d bout pulses", i), bout_cnt - b0, vecs[i].exp_bouts);
        end

        // Wrap latency: bout appears on the 2nd edge after plsi is first sampled low.
        plsi = 1'b1;
        step(4);
        plsi = 1'b0;
        step(2);
        checkOutput("wrap early qout", qout, 0);
        checkOutput("wrap early bout", bout, 0);
        step(1);
        checkOutput("wrap qout", qout, 59);
        checkOutput("wrap bout", bout, 1);
        checkOutput("wrap plso", plso, 1);
        checkOutput("wrap zero", zero, 0);
        step(1);
        checkOutput("wrap bout one cycle", bout, 0);
        checkOutput("wrap hold qout", qout, 59);

        // Clear and tick events land on the same edge: clear wins, tick is dropped.
        applyStimulus(OP_LD, 6'd10);
        b0 = bout_cnt;
        plsi = 1'b1;
        step(4);
        plsi = 1'b0;
        clr = 1'b1;
        step(3);
        checkOutput("clr+tick qout", qout, 0);
        checkOutput("clr+tick zero", zero, 1);
        checkOutput("clr+tick bout", bout, 0);
        step(5);
        checkOutput("clr+tick no deferred tick", qout, 0);
        checkOutput("clr+tick no borrow", bout_cnt - b0, 0);
        clr = 1'b0;
        step(2);
        b0 = bout_cnt;
        pulse();
        checkOutput("after clr tick qout", qout, 59);
        checkOutput("after clr tick bout pulses", bout_cnt - b0, 1);

        // Preset and tick events on the same edge: the preset value is kept.
        applyStimulus(OP_LD, 6'd40);
        plsi = 1'b1;
        step(4);
        plsi = 1'b0;
        step(2);
        ld = 1'b1;
        ld_val = 6'd20;
        step(1);
        ld = 1'b0;
        checkOutput("ld+tick qout", qout, 20);
        checkOutput("ld+tick zero", zero, 0);
        step(3);
        checkOutput("ld+tick no deferred tick", qout, 20);

        // Reset mid-count with a tick about to land.
        applyStimulus(OP_TICK, 6'd0);
        checkOutput("pre-reset qout", qout, 19);
        plsi = 1'b1;
        step(4);
        plsi = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        checkOutput("mid rst qout", qout, 0);
        checkOutput("mid rst zero", zero, 1);
        checkOutput("mid rst bout", bout, 0);
        checkOutput("mid rst plso", plso, 0);
        rst = 1'b0;
        step(3);
        checkOutput("post rst hold", qout, 0);
        b0 = bout_cnt;
        pulse();
        checkOutput("post rst tick qout", qout, 59);
        checkOutput("post rst bout pulses", bout_cnt - b0, 1);

        // WRAP=0 instance holds at zero; WRAP=1 instance wraps on the same ticks.
        doReset();
        b0 = bout_cnt;
        nb0 = nw_bout_cnt;
        for (int k = 0; k < 3; k++)
            pulse();
        checkOutput("nowrap qout", nw_qout, 0);
        checkOutput("nowrap zero", nw_zero, 1);
        checkOutput("nowrap plso", nw_plso, 0);
        checkOutput("nowrap bout pulses", nw_bout_cnt - nb0, 0);
        checkOutput("wrap 3 ticks qout", qout, 57);
        checkOutput("wrap 3 ticks bout pulses", bout_cnt - b0, 1);
        applyStimulus(OP_LD, 6'd2);
        applyStimulus(OP_TICK, 6'd0);
        checkOutput("nowrap decrement qout", nw_qout, 1);
        checkOutput("nowrap decrement zero", nw_zero, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pls_dncnt_60.md
Name: pls_dncnt_60

Overview:
Modulo-60 down-counter for the watch's countdown/timer path. It is the decrementing counterpart of the seconds/minutes up-counter chain.
- Synchronises an external tick (plsi) and decrements on each falling edge.
- Emits a one-cycle borrow pulse to the next-higher stage when it wraps from 0.
- Supports an asynchronous-source clear edge and a synchronous preset load, used when the user sets the timer.

Parameters:
MODULUS, 60, count range 0..MODULUS-1
WIDTH, 6, qout width; must satisfy 2**WIDTH >= MODULUS
WRAP, 1, 1: wrap 0 -> MODULUS-1 with borrow; 0: hold at 0 (timer-expired mode)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
clr  in  1  clear request, async source; acts on rising edge
plsi  in  1  tick input, async source; acts on falling edge
ld  in  1  synchronous single-cycle preset strobe
ld_val  in  WIDTH  preset value
qout  out  WIDTH  current count, registered
plso  out  1  half-period flag: 1 when qout >= MODULUS/2, registered
bout  out  1  borrow pulse, one clk wide, registered
zero  out  1  1 when qout == 0, registered

Behaviour:
- Reset (rst=1 at a clk edge): qout=0, plso=0, bout=0, zero=1. Both synchroniser pipelines cleared to 0.
- Sync: plsi -> p0 -> p1, and clr -> c0 -> c1, one flop each per clk.
  - Tick event: p1 & ~p0. Clear event: c0 & ~c1.
  - Tick latency: qout updates at the 2nd clk edge after the edge that first samples plsi=0.
  - Clear latency: 1 edge after c0 samples 1.
- Priority per cycle: rst > clear event > ld > tick event. The lower-priority event in the same cycle is discarded, not deferred.
- Clear event: qout=0, zero=1, plso=0, bout=0. p0/p1 forced to 0, so a pending plsi edge is dropped.
- ld: qout = ld_val if ld_val < MODULUS, else MODULUS-1 (saturate). bout=0. Flags recomputed from the new qout.
- Tick event:
  - qout > 0: qout = qout-1.
  - qout == 0 and WRAP=1: qout = MODULUS-1, bout=1 for exactly this one cycle.
  - qout == 0 and WRAP=0: qout stays 0, bout stays 0.
- No event: qout holds; bout returns to 0.
- plso and zero are updated on the same edge as qout and are always consistent with the new qout; they are never combinational.
- Arithmetic stays in WIDTH bits; no intermediate value exceeds MODULUS-1.
- rst asserted mid-count overrides everything on that edge. Count restarts from 0 after release.
- A plsi high/low phase shorter than one clk period may be missed; this is accepted, since upstream ticks are multi-cycle.

Decomposition:
- Shared package pls_pkg:
  - constants MOD60=60, CNT_W=6, HALF60=30.
  - function cnt_width(modulus).
  - The existing up-counter is to migrate onto the same constants.
- One sub-module, sync_edge_det: 2-flop synchroniser with registered rise/fall outputs and a synchronous flush input.
  - Instantiated twice: plsi (fall), clr (rise).
- Counter/flag logic stays in pls_dncnt_60.

Test Plan:
- Reset then ld=1, ld_val=5. Apply 5 plsi high->low pulses, each 4 clk high / 4 clk low -> qout 5,4,3,2,1,0; zero=1 after the 5th; bout never 1.
- qout=0, WRAP=1, one plsi fall -> qout=59, plso=1, zero=0; bout=1 for exactly one clk, 2 clk edges after plsi first sampled low.
- WRAP=0, qout=0, 3 plsi pulses -> qout stays 0, bout stays 0, zero stays 1.
- ld_val=63 -> qout=59. ld_val=30 -> plso=1. Then one tick -> qout=29, plso=0.
- clr rising edge in the same cycle as a tick event, qout=10 -> qout=0; tick discarded; next tick -> 59 with bout=1 (WRAP=1).
- ld and tick event in the same cycle, ld_val=20 -> qout=20, not 19. Then rst pulse mid-count -> qout=0, zero=1, bout=0 on that edge.
